// File: rtl/fp_sqrt_state_reg_if.sv
// Handshake/control bundle between the sqrt next-state logic, the state register
// and the FP datapath.
interface fp_sqrt_state_reg_if #(
  parameter int CNT_W = 4
);
  logic             Start_i;
  logic [3:0]       NextState_i;
  logic [3:0]       CurrentState_o;
  logic             LdOperand_o;
  logic             LdExpGuess_o;
  logic [5:0]       IterEn_o;
  logic             CmpEn_o;
  logic             WrResult_o;
  logic [CNT_W-1:0] IterCnt_o;
  logic             Busy_o;
  logic             Done_o;
  logic             Timeout_o;

  modport master (
    output Start_i, NextState_i,
    input  CurrentState_o, LdOperand_o, LdExpGuess_o, IterEn_o, CmpEn_o,
           WrResult_o, IterCnt_o, Busy_o, Done_o, Timeout_o
  );

  modport slave (
    input  Start_i, NextState_i,
    output CurrentState_o, LdOperand_o, LdExpGuess_o, IterEn_o, CmpEn_o,
           WrResult_o, IterCnt_o, Busy_o, Done_o, Timeout_o
  );
endinterface

// File: rtl/fp_sqrt_state_reg.sv
// State register and Moore control decoder for the FP square-root controller, with
// start gating, a Newton-loop watchdog and a Busy/Done handshake.
module fp_sqrt_state_reg #(
  parameter int MAX_ITER = 8,
  parameter int CNT_W    = 4
) (
  input  logic                 Clk_i,
  input  logic                 Rst_n_i,
  fp_sqrt_state_reg_if.slave   bus
);

  typedef enum logic [3:0] {
    S0 = 4'd0, S1 = 4'd1, S2 = 4'd2, S3 = 4'd3, S4 = 4'd4, S5 = 4'd5,
    S6 = 4'd6, S7 = 4'd7, S8 = 4'd8, S9 = 4'd9, S10 = 4'd10
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_ITER - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
  logic             done_q, done_d;
  logic             illegal;

  assign illegal = (state_q > S10);

  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      state_q <= S0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_e'(bus.NextState_i);
    cnt_d   = cnt_q;
    to_d    = to_q;
    done_d  = (state_q == S10);
    if (illegal) begin
      state_d = S0;
    end else if (state_q == S0) begin
      // NextState_i is ignored in idle; only a start request leaves S0.
      state_d = bus.Start_i ? S1 : S0;
      if (bus.Start_i) begin
        cnt_d = '0;
        to_d  = 1'b0;
      end
    end else if (state_q == S9) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        state_d = S10;
        if (bus.NextState_i == 4'(S3)) to_d = 1'b1;
      end
    end
  end

  always_comb begin
    bus.LdOperand_o  = (state_q == S1);
    bus.LdExpGuess_o = (state_q == S2);
    for (int k = 0; k < 6; k++) bus.IterEn_o[k] = (4'(state_q) == 4'(k + 3));
    bus.CmpEn_o      = (state_q == S9);
    bus.WrResult_o   = (state_q == S10);
    bus.Busy_o       = (state_q != S0) && !illegal;
  end

  assign bus.CurrentState_o = 4'(state_q);
  assign bus.IterCnt_o      = cnt_q;
  assign bus.Done_o         = done_q;
  assign bus.Timeout_o      = to_q;

endmodule

// File: tb/tb_fp_sqrt_state_reg.sv
// Directed bench for fp_sqrt_state_reg: a single-pass table plus hand sequences for
// multi-pass loops, watchdog, back-to-back handshake, illegal codes and async reset.
module tb_fp_sqrt_state_reg;

  logic clk = 1'b0;
  logic rst_n;
  logic neg, ill;
  always #5 clk = ~clk;

  fp_sqrt_state_reg_if #(.CNT_W(4)) bus ();

  fp_sqrt_state_reg #(.MAX_ITER(8), .CNT_W(4)) dut (
    .Clk_i  (clk),
    .Rst_n_i(rst_n),
    .bus    (bus)
  );

  // Stand-in for the next-state logic; 'ill' injects an illegal code.
  always_comb begin
    bus.NextState_i = 4'd0;
    if (bus.CurrentState_o == 4'd0) bus.NextState_i = 4'd1;
    else if (bus.CurrentState_o <= 4'd8) bus.NextState_i = bus.CurrentState_o + 4'd1;
    else if (bus.CurrentState_o == 4'd9) bus.NextState_i = neg ? 4'd10 : 4'd3;
    if (ill) bus.NextState_i = 4'd13;
  end

  logic [9:0] strb;
  assign strb = {bus.LdOperand_o, bus.LdExpGuess_o, bus.IterEn_o, bus.CmpEn_o, bus.WrResult_o};

  typedef struct {
    logic       start;
    logic [3:0] st;
    logic [9:0] strb;
    logic       busy;
    logic       done;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      step();
      if (bus.Done_o) begin
        lat = c;
        break;
      end
    end
  endtask

  // Issues one start from S0; lat counts edges after the start edge up to Done_o.
  task automatic run_op(input int passes, output int lat, output int s3_visits,
                        output int iter_err, output logic to_at_start);
    int s9;
    logic [5:0] exp_iter [6];
    exp_iter = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000};
    s9 = 0; lat = -1; s3_visits = 0; iter_err = 0;
    neg = 1'b0;
    bus.Start_i = 1'b1;
    step();
    bus.Start_i = 1'b0;
    to_at_start = bus.Timeout_o;
    for (int c = 1; c <= 200; c++) begin
      if (bus.CurrentState_o == 4'd9) begin
        s9++;
        neg = (s9 >= passes);
      end
      if (bus.CurrentState_o >= 4'd3 && bus.CurrentState_o <= 4'd8) begin
        if (bus.IterEn_o !== exp_iter[bus.CurrentState_o - 4'd3]) iter_err++;
      end
      if (bus.CurrentState_o == 4'd3) s3_visits++;
      step();
      if (bus.Done_o) begin
        lat = c;
        break;
      end
    end
    neg = 1'b0;
  endtask

  vec_t tbl [13];
  int lat, s3v, ierr;
  logic to0;

  initial begin
    tbl[0]  = '{1'b0, 4'd0,  10'b0000000000, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'd1,  10'b1000000000, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 4'd2,  10'b0100000000, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 4'd3,  10'b0000000100, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 4'd4,  10'b0000001000, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 4'd5,  10'b0000010000, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 4'd6,  10'b0000100000, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 4'd7,  10'b0001000000, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 4'd8,  10'b0010000000, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 4'd9,  10'b0000000010, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 4'd10, 10'b0000000001, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 4'd0,  10'b0000000000, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 4'd0,  10'b0000000000, 1'b0, 1'b0};

    rst_n = 1'b0; bus.Start_i = 1'b0; neg = 1'b0; ill = 1'b0;
    #1;
    chk("rst_state", bus.CurrentState_o, 4'd0);
    chk("rst_strb", strb, 10'd0);
    chk("rst_cnt", bus.IterCnt_o, 4'd0);
    chk("rst_done", bus.Done_o, 1'b0);
    chk("rst_to", bus.Timeout_o, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single pass from the table: exit on the first S9.
    neg = 1'b1;
    for (int i = 0; i < 13; i++) begin
      bus.Start_i = tbl[i].start;
      step();
      chk($sformatf("t2_state[%0d]", i), bus.CurrentState_o, tbl[i].st);
      chk($sformatf("t2_strb[%0d]", i), strb, tbl[i].strb);
      chk($sformatf("t2_busy[%0d]", i), bus.Busy_o, tbl[i].busy);
      chk($sformatf("t2_done[%0d]", i), bus.Done_o, tbl[i].done);
    end
    bus.Start_i = 1'b0;
    chk("t2_cnt", bus.IterCnt_o, 4'd1);
    chk("t2_to", bus.Timeout_o, 1'b0);

    // Three passes: 10 + 7*2 edges.
    run_op(3, lat, s3v, ierr, to0);
    chk("t3_lat", lat, 24);
    chk("t3_cnt", bus.IterCnt_o, 4'd3);
    chk("t3_to", bus.Timeout_o, 1'b0);
    chk("t3_s3_visits", s3v, 3);
    chk("t3_iter_onehot", ierr, 0);
    chk("t3_state", bus.CurrentState_o, 4'd0);

    // Watchdog: never converges, forced out after 8 passes: 10 + 7*7 edges.
    run_op(100, lat, s3v, ierr, to0);
    chk("t4_lat", lat, 59);
    chk("t4_cnt", bus.IterCnt_o, 4'd8);
    chk("t4_to", bus.Timeout_o, 1'b1);
    chk("t4_s3_visits", s3v, 8);
    chk("t4_iter_onehot", ierr, 0);
    step();
    chk("t4_to_hold", bus.Timeout_o, 1'b1);
    chk("t4_cnt_hold", bus.IterCnt_o, 4'd8);
    run_op(1, lat, s3v, ierr, to0);
    chk("t4_to_clr", to0, 1'b0);
    chk("t4_next_lat", lat, 10);
    chk("t4_next_cnt", bus.IterCnt_o, 4'd1);

    // Start held high: back-to-back ops, S0 for exactly the Done cycle.
    step();
    neg = 1'b1;
    bus.Start_i = 1'b1;
    step();
    chk("t5_first", bus.CurrentState_o, 4'd1);
    wait_done(lat);
    chk("t5_lat1", lat, 10);
    chk("t5_done_state", bus.CurrentState_o, 4'd0);
    step();
    chk("t5_restart", bus.CurrentState_o, 4'd1);
    chk("t5_busy", bus.Busy_o, 1'b1);
    wait_done(lat);
    chk("t5_lat2", lat, 10);
    bus.Start_i = 1'b0;
    step();
    chk("t5_idle", bus.CurrentState_o, 4'd0);
    chk("t5_done_pulse", bus.Done_o, 1'b0);
    neg = 1'b0;

    // Illegal state code recovers to S0 without Done.
    bus.Start_i = 1'b1;
    step();
    bus.Start_i = 1'b0;
    ill = 1'b1;
    step();
    chk("t6_state13", bus.CurrentState_o, 4'd13);
    chk("t6_strb", strb, 10'd0);
    chk("t6_busy", bus.Busy_o, 1'b0);
    ill = 1'b0;
    step();
    chk("t6_recover", bus.CurrentState_o, 4'd0);
    chk("t6_done0", bus.Done_o, 1'b0);
    step();
    chk("t6_done1", bus.Done_o, 1'b0);

    // Async reset mid-operation at S5, observed before the next edge.
    bus.Start_i = 1'b1;
    step();
    bus.Start_i = 1'b0;
    for (int c = 0; c < 20 && bus.CurrentState_o != 4'd5; c++) step();
    chk("t1_reached_s5", bus.CurrentState_o, 4'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_state", bus.CurrentState_o, 4'd0);
    chk("t1_strb", strb, 10'd0);
    chk("t1_done", bus.Done_o, 1'b0);
    chk("t1_busy", bus.Busy_o, 1'b0);
    chk("t1_cnt", bus.IterCnt_o, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t1_post_state", bus.CurrentState_o, 4'd0);
    chk("t1_post_done", bus.Done_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
